// File: rtl/regfile_2r2w_if.sv
// Bus bundle for regfile_2r2w: two read ports, a byte-masked and a full-word
// write port, the monitor word and the write-collision flag.
interface regfile_2r2w_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int NB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] rs_addr;
  logic [ADDR_WIDTH-1:0] rt_addr;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] wa0;
  logic [DATA_WIDTH-1:0] wd0;
  logic [NB-1:0]         wbe0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] wa1;
  logic [DATA_WIDTH-1:0] wd1;
  logic [DATA_WIDTH-1:0] mon_data;
  logic                  wr_conflict;

  modport master (
    output rs_addr, rt_addr, we0, wa0, wd0, wbe0, we1, wa1, wd1,
    input  rs_data, rt_data, mon_data, wr_conflict
  );

  modport slave (
    input  rs_addr, rt_addr, we0, wa0, wd0, wbe0, we1, wa1, wd1,
    output rs_data, rt_data, mon_data, wr_conflict
  );
endinterface

// File: rtl/regfile_2r2w.sv
// Two-read / two-write register file with byte-masked primary write, full-word
// secondary write, optional hardwired zero register, optional write bypass.
module regfile_2r2w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  parameter int MON_ADDR   = 2
) (
  input  logic           clk,
  input  logic           reset,
  regfile_2r2w_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] MON_IDX = ADDR_WIDTH'(MON_ADDR);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DATA_WIDTH-1:0] lane_mask0;
  logic                  eff0;
  logic                  eff1;
  logic                  conflict;
  logic [DATA_WIDTH-1:0] rs_val;
  logic [DATA_WIDTH-1:0] rt_val;
  logic [DATA_WIDTH-1:0] mon_val;
  logic [DATA_WIDTH-1:0] rs_data_q;
  logic [DATA_WIDTH-1:0] rt_data_q;
  logic [DATA_WIDTH-1:0] mon_data_q;
  logic                  wr_conflict_q;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_mask0[8*gi +: 8] = {8{bus.wbe0[gi]}};
    end
  endgenerate

  assign eff0 = bus.we0 && (bus.wbe0 != '0) && !(ZERO_REG && (bus.wa0 == '0));
  assign eff1 = bus.we1 && !(ZERO_REG && (bus.wa1 == '0));
  assign conflict = eff0 && eff1 && (bus.wa0 == bus.wa1);

  // Port 1 lays down the full word first; port 0's enabled lanes then win,
  // which yields the collision merge with no special case.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = (eff1 && (bus.wa1 == ADDR_WIDTH'(i))) ? bus.wd1 : regs_q[i];
      if (eff0 && (bus.wa0 == ADDR_WIDTH'(i))) begin
        regs_d[i] = (bus.wd0 & lane_mask0) | (regs_d[i] & ~lane_mask0);
      end
    end
  end

  assign rs_val  = (ZERO_REG && (bus.rs_addr == '0)) ? '0 :
                   (BYPASS ? regs_d[bus.rs_addr] : regs_q[bus.rs_addr]);
  assign rt_val  = (ZERO_REG && (bus.rt_addr == '0)) ? '0 :
                   (BYPASS ? regs_d[bus.rt_addr] : regs_q[bus.rt_addr]);
  assign mon_val = (ZERO_REG && (MON_IDX == '0)) ? '0 :
                   (BYPASS ? regs_d[MON_IDX] : regs_q[MON_IDX]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      mon_data_q    <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rs_data_q     <= rs_val;
      rt_data_q     <= rt_val;
      mon_data_q    <= mon_val;
      wr_conflict_q <= conflict;
    end
  end

  assign bus.rs_data     = rs_data_q;
  assign bus.rt_data     = rt_data_q;
  assign bus.mon_data    = mon_data_q;
  assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_regfile_2r2w.sv
// Bench for regfile_2r2w: default build (zero reg, bypass) and an alternate build
// (no zero reg, no bypass) driven in lockstep and checked against an array model.
module tb_regfile_2r2w;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] rs_addr, rt_addr, wa0, wa1;
  logic [DW-1:0] wd0, wd1;
  logic [3:0]    wbe0;
  logic          we0, we1;

  int tests_run = 0;
  int tests_failed = 0;

  // config 0 = ZERO_REG=1,BYPASS=1 ; config 1 = ZERO_REG=0,BYPASS=0
  bit zr_cfg [2] = '{1'b1, 1'b0};
  bit bp_cfg [2] = '{1'b1, 1'b0};
  logic [DW-1:0] m [2][DEPTH];

  regfile_2r2w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  regfile_2r2w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  assign ifa.rs_addr = rs_addr;  assign ifb.rs_addr = rs_addr;
  assign ifa.rt_addr = rt_addr;  assign ifb.rt_addr = rt_addr;
  assign ifa.we0 = we0;          assign ifb.we0 = we0;
  assign ifa.wa0 = wa0;          assign ifb.wa0 = wa0;
  assign ifa.wd0 = wd0;          assign ifb.wd0 = wd0;
  assign ifa.wbe0 = wbe0;        assign ifb.wbe0 = wbe0;
  assign ifa.we1 = we1;          assign ifb.we1 = we1;
  assign ifa.wa1 = wa1;          assign ifb.wa1 = wa1;
  assign ifa.wd1 = wd1;          assign ifb.wd1 = wd1;

  regfile_2r2w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b1), .MON_ADDR(2))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  regfile_2r2w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b0), .BYPASS(1'b0), .MON_ADDR(2))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0;
    wd0 = '0; wd1 = '0; wbe0 = '0;
  endtask

  task automatic clear_model();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < DEPTH; r++) m[c][r] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/A.rs"},  ifa.rs_data, '0);
    check({tag, "/A.rt"},  ifa.rt_data, '0);
    check({tag, "/A.mon"}, ifa.mon_data, '0);
    check({tag, "/A.wc"},  {31'b0, ifa.wr_conflict}, '0);
    check({tag, "/B.rs"},  ifb.rs_data, '0);
    check({tag, "/B.rt"},  ifb.rt_data, '0);
    check({tag, "/B.mon"}, ifb.mon_data, '0);
    check({tag, "/B.wc"},  {31'b0, ifb.wr_conflict}, '0);
  endtask

  // One clock edge: the model applies the write rules to a copy of the
  // register contents, then all outputs of both builds are compared.
  task automatic step(input string tag);
    logic [DW-1:0] nm [2][DEPTH];
    logic [DW-1:0] lmask;
    logic [DW-1:0] xrs [2], xrt [2], xmon [2];
    bit xc [2];
    bit e0, e1;
    for (int b = 0; b < 4; b++) lmask[8*b +: 8] = wbe0[b] ? 8'hFF : 8'h00;
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < DEPTH; r++) nm[c][r] = m[c][r];
      e0 = we0 && (wbe0 != 0) && !(zr_cfg[c] && wa0 == 0);
      e1 = we1 && !(zr_cfg[c] && wa1 == 0);
      if (e0 && e1 && wa0 == wa1) begin
        nm[c][wa0] = (wd0 & lmask) | (wd1 & ~lmask);
      end else begin
        if (e0) nm[c][wa0] = (wd0 & lmask) | (m[c][wa0] & ~lmask);
        if (e1) nm[c][wa1] = wd1;
      end
      xrs[c]  = (zr_cfg[c] && rs_addr == 0) ? '0 : (bp_cfg[c] ? nm[c][rs_addr] : m[c][rs_addr]);
      xrt[c]  = (zr_cfg[c] && rt_addr == 0) ? '0 : (bp_cfg[c] ? nm[c][rt_addr] : m[c][rt_addr]);
      xmon[c] = bp_cfg[c] ? nm[c][2] : m[c][2];
      xc[c]   = e0 && e1 && (wa0 == wa1);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < DEPTH; r++) m[c][r] = nm[c][r];
    check({tag, "/A.rs"},  ifa.rs_data, xrs[0]);
    check({tag, "/A.rt"},  ifa.rt_data, xrt[0]);
    check({tag, "/A.mon"}, ifa.mon_data, xmon[0]);
    check({tag, "/A.wc"},  {31'b0, ifa.wr_conflict}, {31'b0, xc[0]});
    check({tag, "/B.rs"},  ifb.rs_data, xrs[1]);
    check({tag, "/B.rt"},  ifb.rt_data, xrt[1]);
    check({tag, "/B.mon"}, ifb.mon_data, xmon[1]);
    check({tag, "/B.wc"},  {31'b0, ifb.wr_conflict}, {31'b0, xc[1]});
  endtask

  function automatic logic [AW-1:0] pick_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
  endfunction

  initial begin
    idle();
    rs_addr = '0; rt_addr = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    reset = 1'b1;

    // Preload reg5 and the monitored reg2, then assert reset between edges
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEADBEEF; step("pre5");
    we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h0BADF00D; step("pre2");
    idle(); rs_addr = 5'd5; rt_addr = 5'd5; step("rd5");
    check("rd5_const", ifa.rs_data, 32'hDEADBEEF);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    clear_model();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12121212; wbe0 = 4'hF;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h34343434;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_held");
    idle();
    reset = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rs_addr = AW'(2 * a); rt_addr = AW'(2 * a + 1);
      step($sformatf("scan%0d", a));
    end

    // Byte-lane merge
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h11223344; step("merge_pre");
    idle(); we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAABBCCDD; wbe0 = 4'b0101; rs_addr = 5'd3;
    step("merge_wr");
    idle(); step("merge_rd");
    check("merge_A", ifa.rs_data, 32'h11BB33DD);
    check("merge_B", ifb.rs_data, 32'h11BB33DD);

    // Register 0 write via port 1
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; rs_addr = 5'd0; step("zero_wr");
    check("zero_wc_A", {31'b0, ifa.wr_conflict}, '0);
    idle(); step("zero_rd");
    check("zero_A", ifa.rs_data, 32'h0);
    check("zero_B", ifb.rs_data, 32'hFFFFFFFF);

    // Same-edge write and read of reg7
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hCAFEF00D; step("byp_pre");
    idle(); we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h12345678; wbe0 = 4'hF; rs_addr = 5'd7;
    step("byp_wr");
    check("byp_A", ifa.rs_data, 32'h12345678);
    check("byp_B_old", ifb.rs_data, 32'hCAFEF00D);
    idle(); step("byp_next");
    check("byp_B_new", ifb.rs_data, 32'h12345678);

    // Collision on reg9
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0; step("col_pre");
    idle(); we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h000000AA; wbe0 = 4'b0001;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h55555555; rs_addr = 5'd9;
    step("col_wr");
    check("col_A", ifa.rs_data, 32'h555555AA);
    check("col_wc1", {31'b0, ifa.wr_conflict}, 32'h1);
    idle(); step("col_after");
    check("col_wc0", {31'b0, ifa.wr_conflict}, 32'h0);
    check("col_B", ifb.rs_data, 32'h555555AA);

    // Dual write to distinct registers, monitor on reg2
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h00000042; wbe0 = 4'hF;
    we1 = 1'b1; wa1 = 5'd31; wd1 = 32'h80000000; rt_addr = 5'd31;
    step("dual_wr");
    check("dual_mon_A", ifa.mon_data, 32'h00000042);
    check("dual_rt_A", ifa.rt_data, 32'h80000000);
    check("dual_wc_A", {31'b0, ifa.wr_conflict}, 32'h0);
    idle(); step("dual_next");
    check("dual_mon_B", ifb.mon_data, 32'h00000042);
    check("dual_rt_B", ifb.rt_data, 32'h80000000);

    // Randomized traffic biased toward low addresses for collisions and reg0
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = pick_addr(); wd0 = $urandom(); wbe0 = 4'($urandom_range(0, 15));
      we1 = 1'($urandom_range(0, 1)); wa1 = pick_addr(); wd1 = $urandom();
      rs_addr = pick_addr(); rt_addr = pick_addr();
      step($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
